wb_arbiter: RTL
===============

# wb_arbiter

Write-back arbiter that owns the single write port of the 32×32 general-purpose register file. It merges two result sources into one stream of register writes: the in-order pipeline write-back stage, which can never stall, and a long-latency unit (divider/multiplier) that uses a valid/ready handshake. Long-latency results wait in a small FIFO. The block also reports per-address pending-write status so the decode stage can stall on hazards the register file bypass cannot cover.

## Interface
Parameters:
- ADDR_W, 5: register address width.
- DATA_W, 32: register data width.
- DEPTH, 4: FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous and active-low (0 = reset).
- pipe_we  in  1  write request from the pipeline write-back stage.
- pipe_waddr  in  ADDR_W  destination register of the pipeline write.
- pipe_wdata  in  DATA_W  data for the pipeline write.
- lu_valid  in  1  long-latency unit has a result.
- lu_ready  out  1  FIFO can accept a result.
- lu_waddr  in  ADDR_W  destination register of the long-latency result.
- lu_wdata  in  DATA_W  data for the long-latency result.
- we  out  1  register file write enable (registered).
- waddr  out  ADDR_W  register file write address (registered).
- wdata  out  DATA_W  register file write data (registered).
- chk_addr1, chk_addr2  in  ADDR_W  decode-stage source addresses to check.
- chk_busy1, chk_busy2  out  1  a live FIFO entry targets that address.
- fifo_count  out  log2(DEPTH)+1  number of occupied FIFO entries, live or killed.

## Operation
- **Accept:** a long-latency result is accepted when lu_valid && lu_ready.
  - lu_ready = (fifo_count != DEPTH). It is combinational from registered state only and ignores any pop in the same cycle.
- **Address 0:** an accepted result with lu_waddr == 0 completes the handshake but is not enqueued. A pipeline write with pipe_waddr == 0 is ignored completely.
- **Output select, each cycle, priority order:**
  - Pipeline write (pipe_we && pipe_waddr != 0): the output register loads it, we=1.
  - Otherwise, if the FIFO is not empty, pop the head. If the head is live, we=1 with its address and data. If it is killed, we=0.
  - Otherwise, we=0; waddr and wdata hold their previous values.
- **Kill rule (newer write wins):**
  - A pipeline write to address A clears the live bit of every FIFO entry whose address is A.
  - A long-latency result accepted in the same cycle with lu_waddr == A is treated as older. It completes the handshake but is not enqueued.
- **Busy check:** chk_busyN = (chk_addrN != 0) && (some live FIFO entry has address chk_addrN).
  - The check is combinational and excludes the output register, because the register file forwards same-cycle writes to its read ports.
  - It excludes a push in the current cycle; a newly pushed entry shows busy from the next cycle.
- **FIFO:** circular buffer with read/write pointers that wrap modulo DEPTH. Push and pop in the same cycle are legal when the FIFO is neither empty nor full before the edge; the count is unchanged.
- The FIFO never overflows, because lu_ready gates every push. A pop from an empty FIFO never occurs.

## Timing
- **Reset (rst=0, asynchronous):**
  - we=0, waddr=0, wdata=0.
  - Pointers and count = 0, all live bits = 0.
  - Outputs during reset: chk_busy1/2=0 and lu_ready=1.
- **Pipeline latency:** a pipeline write presented before edge N appears on we/waddr/wdata after edge N (1 cycle).
- **Long-latency latency:** a result accepted at edge N is enqueued at edge N and can be popped at the earliest at edge N+1. Minimum latency is 2 cycles; it grows by 1 for each cycle a pipeline write takes the port.
- **Starvation:** the FIFO drains only in cycles without a pipeline write. Sustained pipeline writes hold lu_ready low once the FIFO is full. This is accepted; no fairness is required.
- **Handshake:** the producer holds lu_valid, lu_waddr and lu_wdata stable until accepted. The arbiter never retracts lu_ready except because the FIFO is full.
- **Reset mid-operation:** all queued entries are discarded. we drops to 0 immediately when rst falls, with no wait for a clock edge.

## Test plan
- **Reset values:** apply reset with lu_valid=1 and FIFO state arbitrary → we=0, waddr=0, wdata=0, fifo_count=0, lu_ready=1, chk_busy1=chk_busy2=0 immediately.
- **Idle-port latency:** lu write (r5, 0xDEADBEEF) accepted at edge 0 with no pipeline writes → chk_busy1=1 for chk_addr1=5 after edge 0; we=1, waddr=5, wdata=0xDEADBEEF after edge 1; busy clears after edge 1.
- **Fill and drain:** 4 lu writes to r1..r4 while pipe_we=1 to r10 every cycle → lu_ready=0 after the 4th accept and fifo_count=4. Then stop pipe_we → r1..r4 appear in order on 4 consecutive cycles and lu_ready=1 after the first pop.
- **Kill rule:** queue lu write (r7, 0x11), then pipe write (r7, 0x22) → we=1 with r7=0x22. The later pop of the killed entry gives we=0 and chk_busy for r7 stays 0. Also drive same-cycle lu write (r9) and pipe write (r9) → only the pipe data is written and fifo_count is unchanged.
- **Register 0:** lu write to r0 and pipe write to r0 → handshake completes, fifo_count unchanged, we never asserted, chk_busy for address 0 always 0.
- **Wrap and mid-operation reset:** 10 push/pop cycles with pointers wrapping → write order and data match the accepted order. Then assert rst with 3 entries queued → fifo_count=0 and no queued write reaches we after reset is released.

Source files
------------

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges non-stalling pipeline writes with queued long-latency
// results onto the single register-file write port, with per-address pending-write checks.
module wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_we,
    input  logic [ADDR_W-1:0]        pipe_waddr,
    input  logic [DATA_W-1:0]        pipe_wdata,
    input  logic                     lu_valid,
    output logic                     lu_ready,
    input  logic [ADDR_W-1:0]        lu_waddr,
    input  logic [DATA_W-1:0]        lu_wdata,
    output logic                     we,
    output logic [ADDR_W-1:0]        waddr,
    output logic [DATA_W-1:0]        wdata,
    input  logic [ADDR_W-1:0]        chk_addr1,
    input  logic [ADDR_W-1:0]        chk_addr2,
    output logic                     chk_busy1,
    output logic                     chk_busy2,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_live;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    logic w_pipe;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_busy1;
    logic w_busy2;

    assign w_pipe   = pipe_we && (pipe_waddr != '0);
    assign lu_ready = (r_count != CNT_W'(DEPTH));
    assign w_accept = lu_valid && lu_ready;
    // A same-cycle pipeline write to the same register supersedes the older result.
    assign w_push   = w_accept && (lu_waddr != '0) && !(w_pipe && (lu_waddr == pipe_waddr));
    assign w_pop    = !w_pipe && (r_count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_live  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_pipe) begin
                r_we    <= 1'b1;
                r_waddr <= pipe_waddr;
                r_wdata <= pipe_wdata;
            end else if (w_pop) begin
                r_we <= r_live[r_head];
                if (r_live[r_head]) begin
                    r_waddr <= r_addr[r_head];
                    r_wdata <= r_data[r_head];
                end
            end else begin
                r_we <= 1'b0;
            end

            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_pipe && (r_addr[i] == pipe_waddr)) begin
                    r_live[i] <= 1'b0;
                end
            end

            if (w_pop) begin
                r_live[r_head] <= 1'b0;
                r_head         <= r_head + PTR_W'(1);
            end

            if (w_push) begin
                r_addr[r_tail] <= lu_waddr;
                r_data[r_tail] <= lu_wdata;
                r_live[r_tail] <= 1'b1;
                r_tail         <= r_tail + PTR_W'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Only live entries count; the output register is covered by register-file forwarding.
    always_comb begin
        w_busy1 = 1'b0;
        w_busy2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_live[i] && (r_addr[i] == chk_addr1)) w_busy1 = 1'b1;
            if (r_live[i] && (r_addr[i] == chk_addr2)) w_busy2 = 1'b1;
        end
    end

    assign chk_busy1  = w_busy1 && (chk_addr1 != '0);
    assign chk_busy2  = w_busy2 && (chk_addr2 != '0);
    assign we         = r_we;
    assign waddr      = r_waddr;
    assign wdata      = r_wdata;
    assign fifo_count = r_count;

endmodule
